// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI byte receiver.
package spi_pkg;
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LOAD  = 2'd2
    } state_t;

    localparam int   SPI_BITS  = 8;
    localparam logic SCLK_IDLE = 1'b1;
    localparam logic CS_IDLE   = 1'b1;
endpackage

// File: rtl/spi_readbyte_if.sv
// SPI pins plus the received-byte valid/ready handshake, grouped as one bundle.
interface spi_readbyte_if;
    import spi_pkg::*;

    logic                sclk;
    logic                mosi;
    logic                cs_n;
    logic [SPI_BITS-1:0] data;
    logic                rx_valid;
    logic                rx_ready;
    logic                rx_busy;
    logic                overrun;
    logic                frame_err;

    modport master (
        output sclk, mosi, cs_n, rx_ready,
        input  data, rx_valid, rx_busy, overrun, frame_err
    );

    modport slave (
        input  sclk, mosi, cs_n, rx_ready,
        output data, rx_valid, rx_busy, overrun, frame_err
    );
endinterface

// File: rtl/spi_sync.sv
// N-stage flop synchronizer with a configurable reset level.
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain <= {STAGES{RST_VAL}};
        else        chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];
endmodule

// File: rtl/spi_readbyte.sv
// Mode-3 SPI byte receiver, oversampled by clk, bytes delivered on valid/ready.
// Optional partial-byte timeout enabled by defining SPI_RX_TIMEOUT_EN.
module spi_readbyte
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    spi_readbyte_if.slave  bus
);
    logic sclk_s, mosi_s, cs_n_s, sclk_prev, rise;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(SCLK_IDLE)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d(bus.sclk), .q(sclk_s));
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .d(bus.mosi), .q(mosi_s));
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CS_IDLE)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .d(bus.cs_n), .q(cs_n_s));

    state_t              state, state_n;
    logic [3:0]          cnt, cnt_n;
    logic [SPI_BITS-1:0] shift_reg, shift_n, data_q, data_n;
    logic                valid_q, valid_n, ovr_q, ovr_n, ferr_q, ferr_n;
    logic                busy;

    assign rise = sclk_s && !sclk_prev;
    assign busy = (state == S_SHIFT) && (cnt != 4'd0) && (cnt < 4'(SPI_BITS));

`ifdef SPI_RX_TIMEOUT_EN
    logic [15:0] idle_cnt, idle_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) idle_cnt <= '0;
        else        idle_cnt <= idle_n;
    end
`else
    logic [15:0] unused_timeout;
    assign unused_timeout = 16'(TIMEOUT_CYCLES);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            shift_reg <= '0;
            sclk_prev <= SCLK_IDLE;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ovr_q     <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            shift_reg <= shift_n;
            sclk_prev <= sclk_s;
            data_q    <= data_n;
            valid_q   <= valid_n;
            ovr_q     <= ovr_n;
            ferr_q    <= ferr_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        shift_n = shift_reg;
        data_n  = data_q;
        valid_n = valid_q && !bus.rx_ready;
        ovr_n   = 1'b0;
        ferr_n  = 1'b0;
`ifdef SPI_RX_TIMEOUT_EN
        idle_n  = '0;
`endif
        case (state)
            S_IDLE: begin
                if (!cs_n_s) begin
                    state_n = S_SHIFT;
                    cnt_n   = '0;
                end
            end
            S_SHIFT: begin
                // A completed byte wins over a deselect seen in the same cycle.
                if (cnt == 4'(SPI_BITS)) begin
                    state_n = S_LOAD;
                end else if (cs_n_s) begin
                    state_n = S_IDLE;
                    ferr_n  = (cnt != 4'd0);
                    cnt_n   = '0;
                end else if (rise) begin
                    shift_n = {shift_reg[SPI_BITS-2:0], mosi_s};
                    cnt_n   = cnt + 4'd1;
`ifdef SPI_RX_TIMEOUT_EN
                end else if (busy) begin
                    if (idle_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                        ferr_n  = 1'b1;
                        cnt_n   = '0;
                        shift_n = '0;
                    end else begin
                        idle_n = idle_cnt + 16'd1;
                    end
`endif
                end
            end
            S_LOAD: begin
                if (!valid_q || bus.rx_ready) begin
                    data_n  = shift_reg;
                    valid_n = 1'b1;
                end else begin
                    valid_n = 1'b1;
                    ovr_n   = 1'b1;
                end
                state_n = cs_n_s ? S_IDLE : S_SHIFT;
                cnt_n   = '0;
                // An edge landing here is the first bit of the next byte.
                if (rise && !cs_n_s) begin
                    shift_n = {shift_reg[SPI_BITS-2:0], mosi_s};
                    cnt_n   = 4'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign bus.data      = data_q;
    assign bus.rx_valid  = valid_q;
    assign bus.rx_busy   = busy;
    assign bus.overrun   = ovr_q;
    assign bus.frame_err = ferr_q;
endmodule

// File: tb/tb_spi_readbyte.sv
// Directed + randomized bench for spi_readbyte: SPI master tasks, byte-level reference expectations.
module tb_spi_readbyte;
    localparam int SYNC = 2;

    logic clk;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    spi_readbyte_if bus ();

    spi_readbyte #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: accepted bytes and pulse/level counters, sampled mid-cycle.
    logic [7:0] got_q[$];
    int ovr_cnt = 0, ferr_cnt = 0, vhigh_cnt = 0, vlow_cnt = 0;
    bit watch_low = 0;

    always @(negedge clk) begin
        if (bus.rx_valid && bus.rx_ready) got_q.push_back(bus.data);
        if (bus.overrun)   ovr_cnt++;
        if (bus.frame_err) ferr_cnt++;
        if (bus.rx_valid)  vhigh_cnt++;
        if (watch_low && !bus.rx_valid) vlow_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_rx(input string tag, input logic [7:0] exp);
        logic [7:0] g;
        int         n;
        n = got_q.size();
        g = (n > 0) ? got_q[0] : 8'h00;
        tests++;
        assert (n > 0 && g === exp) else begin
            fails++;
            $error("FAIL %s: got %0h (queued %0d) expected %0h", tag, g, n, exp);
        end
        if (n > 0) void'(got_q.pop_front());
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends the top n bits of b, MSB first, sclk = clk/4, leaving sclk high.
    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            bus.sclk = 1'b0;
            bus.mosi = b[7-i];
            tick(2);
            bus.sclk = 1'b1;
            tick(2);
        end
    endtask

    // Full byte; lat = clk edges from the first edge seeing the 8th sclk high until rx_valid is seen.
    // pulse raises rx_ready for exactly the cycle the finished byte is being loaded.
    task automatic send_byte(input logic [7:0] b, input bit pulse, output int lat);
        bit seen;
        seen = 0;
        lat  = 0;
        send_bits(b, 7);
        bus.sclk = 1'b0;
        bus.mosi = b[0];
        tick(2);
        bus.sclk = 1'b1;
        for (int k = 1; k <= SYNC + 3; k++) begin
            @(posedge clk);
            #1;
            if (pulse && k == SYNC + 2)      bus.rx_ready = 1'b1;
            else if (pulse && k == SYNC + 3) bus.rx_ready = 1'b0;
            if (!seen && bus.rx_valid) begin
                seen = 1;
                lat  = k;
            end
        end
    endtask

    initial begin
        logic [7:0] sent[$];
        logic [7:0] b, hi;
        int lat, o0, f0, v0;

        rst_n        = 1'b0;
        bus.sclk     = 1'b1;
        bus.mosi     = 1'b0;
        bus.cs_n     = 1'b1;
        bus.rx_ready = 1'b0;
        #3;
        chk("reset_data",  {24'd0, bus.data}, 32'h00);
        chk("reset_valid", {31'd0, bus.rx_valid}, 0);
        chk("reset_busy",  {31'd0, bus.rx_busy}, 0);
        chk("reset_ovr",   {31'd0, bus.overrun}, 0);
        chk("reset_ferr",  {31'd0, bus.frame_err}, 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        bus.cs_n = 1'b0;
        tick(5);

        // Single byte with consumer always ready.
        bus.rx_ready = 1'b1;
        o0 = ovr_cnt; f0 = ferr_cnt; v0 = vhigh_cnt;
        send_byte(8'hA5, 0, lat);
        tick(6);
        chk("a5_latency", lat, SYNC + 3);
        expect_rx("a5_data", 8'hA5);
        chk("a5_valid_cycles", vhigh_cnt - v0, 1);
        chk("a5_ovr", ovr_cnt - o0, 0);
        chk("a5_ferr", ferr_cnt - f0, 0);

        // Random back-to-back stream, consumer ready: every byte arrives in order.
        o0 = ovr_cnt;
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom_range(0, 255));
            sent.push_back(b);
            send_byte(b, 0, lat);
        end
        tick(6);
        while (sent.size() > 0) expect_rx("stream_byte", sent.pop_front());
        chk("stream_ovr", ovr_cnt - o0, 0);

        // Consumer stalled: first byte kept, each further byte dropped.
        bus.rx_ready = 1'b0;
        o0 = ovr_cnt;
        send_byte(8'h3C, 0, lat);
        send_byte(8'hFF, 0, lat);
        tick(6);
        chk("stall_data",  {24'd0, bus.data}, 32'h3C);
        chk("stall_valid", {31'd0, bus.rx_valid}, 1);
        chk("stall_ovr",   ovr_cnt - o0, 1);
        bus.rx_ready = 1'b1;
        tick(1);
        bus.rx_ready = 1'b0;
        tick(2);
        expect_rx("stall_consume", 8'h3C);
        chk("stall_valid_cleared", {31'd0, bus.rx_valid}, 0);

        // Consume and load in the same cycle.
        send_byte(8'h42, 0, lat);
        tick(4);
        chk("pend_data", {24'd0, bus.data}, 32'h42);
        o0 = ovr_cnt;
        vlow_cnt  = 0;
        watch_low = 1;
        send_byte(8'h81, 1, lat);
        tick(3);
        watch_low = 0;
        expect_rx("swap_old", 8'h42);
        chk("swap_data",   {24'd0, bus.data}, 32'h81);
        chk("swap_valid",  {31'd0, bus.rx_valid}, 1);
        chk("swap_no_gap", vlow_cnt, 0);
        chk("swap_ovr",    ovr_cnt - o0, 0);
        bus.rx_ready = 1'b1;
        tick(2);
        expect_rx("swap_consume", 8'h81);

        // Deselect mid-byte.
        f0 = ferr_cnt;
        send_bits(8'($urandom_range(0, 255)), 5);
        tick(3);
        chk("partial_busy", {31'd0, bus.rx_busy}, 1);
        bus.cs_n = 1'b1;
        tick(8);
        chk("partial_ferr", ferr_cnt - f0, 1);
        chk("partial_busy_low", {31'd0, bus.rx_busy}, 0);
        bus.cs_n = 1'b0;
        tick(5);
        send_byte(8'h0F, 0, lat);
        tick(6);
        expect_rx("after_abort", 8'h0F);

        // Reset mid-byte with a byte pending.
        bus.rx_ready = 1'b0;
        b = 8'($urandom_range(1, 255));
        send_byte(b, 0, lat);
        tick(4);
        chk("pre_reset_data", {24'd0, bus.data}, {24'd0, b});
        send_bits(8'($urandom_range(0, 255)), 3);
        tick(3);
        chk("pre_reset_busy", {31'd0, bus.rx_busy}, 1);
        f0 = ferr_cnt;
        rst_n = 1'b0;
        #1;
        chk("rst_data",  {24'd0, bus.data}, 32'h00);
        chk("rst_valid", {31'd0, bus.rx_valid}, 0);
        chk("rst_busy",  {31'd0, bus.rx_busy}, 0);
        chk("rst_ovr",   {31'd0, bus.overrun}, 0);
        chk("rst_ferr",  {31'd0, bus.frame_err}, 0);
        tick(2);
        rst_n = 1'b1;
        bus.rx_ready = 1'b1;
        tick(5);
        send_byte(8'hC3, 0, lat);
        tick(6);
        expect_rx("after_reset", 8'hC3);
        chk("reset_no_ferr", ferr_cnt - f0, 0);

        // Stalled partial byte.
        f0 = ferr_cnt;
        hi = 8'($urandom_range(0, 255));
        send_bits(hi, 4);
        tick(100);
`ifdef SPI_RX_TIMEOUT_EN
        chk("timeout_ferr", ferr_cnt - f0, 1);
        chk("timeout_busy", {31'd0, bus.rx_busy}, 0);
        send_byte(8'h55, 0, lat);
        tick(6);
        expect_rx("after_timeout", 8'h55);
`else
        chk("no_timeout_ferr", ferr_cnt - f0, 0);
        chk("no_timeout_busy", {31'd0, bus.rx_busy}, 1);
        b = 8'($urandom_range(0, 255));
        send_bits({b[3:0], 4'h0}, 4);
        tick(8);
        expect_rx("completed_late", {hi[7:4], b[3:0]});
`endif
        chk("no_extra_bytes", got_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
